// File: rtl/forward_hazard_unit.sv
// EX-stage forwarding selects, load-use stall/bubble, branch flush and
// saturating stall/flush counters for the 5-stage RV32 pipeline.
module forward_hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             ex_branch_taken,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             stall,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use_rs1;
        logic       use_rs2;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } ex_rec_t;

    // MEM and WB only ever act as producers, so they keep just the writer fields.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
    } wr_rec_t;

    ex_rec_t ex_q;
    ex_rec_t id_rec;
    wr_rec_t mem_q;
    wr_rec_t wb_q;
    logic    raw_stall;

    function automatic logic writes_reg(input wr_rec_t p, input logic [4:0] r);
        return p.valid && p.regwrite && (p.rd != 5'd0) && (p.rd == r);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic ex_valid, input logic use_rs,
                                           input logic [4:0] rs,
                                           input wr_rec_t mem, input wr_rec_t wb);
        logic [1:0] sel;
        sel = 2'b00;
        if (ex_valid && use_rs) begin
            if (writes_reg(mem, rs))
                sel = 2'b10;
            else if (writes_reg(wb, rs))
                sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        // NOTE: every output of this block is assigned on all paths, so no latch is inferred.
        raw_stall = id_valid && ex_q.valid && ex_q.memread && (ex_q.rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_q.rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_q.rd)));
        stall        = raw_stall && !ex_branch_taken;
        id_ex_bubble = stall || ex_branch_taken;
        if_id_flush  = ex_branch_taken;

        forward_a = fwd_sel(ex_q.valid, ex_q.use_rs1, ex_q.rs1, mem_q, wb_q);
        forward_b = fwd_sel(ex_q.valid, ex_q.use_rs2, ex_q.rs2, mem_q, wb_q);

        id_rec.valid    = id_valid && !id_ex_bubble;
        id_rec.rs1      = id_rs1;
        id_rec.rs2      = id_rs2;
        id_rec.use_rs1  = id_use_rs1;
        id_rec.use_rs2  = id_use_rs2;
        id_rec.rd       = id_rd;
        id_rec.regwrite = id_regwrite;
        id_rec.memread  = id_memread;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q         <= '0;
            mem_q        <= '0;
            wb_q         <= '0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            // NOTE: non-blocking so WB, MEM and EX all shift from pre-edge values.
            wb_q  <= mem_q;
            mem_q <= '{valid: ex_q.valid, rd: ex_q.rd, regwrite: ex_q.regwrite};
            ex_q  <= id_rec;
            if (stall && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + 1'b1;
            if (ex_branch_taken && (flush_count != {CNT_W{1'b1}}))
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule
